// File: rtl/clk_gen_pkg.sv
// Shared definitions for the half-period clock generator.
//   CNT_W_DEF   : default half-period counter width
//   EC_W_DEF    : default toggle-counter width
//   HP_MIN      : smallest legal half period (a loaded 0 is promoted to this)
//   hp_in_range : constant function used to validate HALF_PERIOD at elaboration
package clk_gen_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned EC_W_DEF  = 32;
  localparam int unsigned HP_MIN    = 1;

  // True when HP_MIN <= hp < 2**w. The shift is done in 64 bits so w=32 still works.
  function automatic bit hp_in_range(longint unsigned hp, int unsigned w);
    longint unsigned limit;
    limit = longint'(1) << w;
    return (hp >= longint'(HP_MIN)) && (hp < limit);
  endfunction

endpackage

// File: rtl/clk_half_period_counter.sv
// Half-period counter: holds the current half period and counts clk cycles within a phase.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   en       : run enable; low freezes the count
//   hp_load  : loads hp_value as the new half period and restarts the count
//   hp_value : new half period, 0 treated as HP_MIN
//   terminal : high in the cycle whose rising clk edge ends the current phase
module clk_half_period_counter
  import clk_gen_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hp_load,
  input  logic [CNT_W-1:0] hp_value,
  output logic             terminal
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hp;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_hp_d;
  logic             w_last;

  assign w_last = (r_cnt == (r_hp - CNT_W'(1)));

  // A load always wins: it restarts the phase count and suppresses a toggle that was due.
  assign terminal = en && !hp_load && w_last;

  always_comb begin
    w_cnt_d = r_cnt;
    w_hp_d  = r_hp;
    if (hp_load) begin
      w_hp_d  = (hp_value == '0) ? CNT_W'(HP_MIN) : hp_value;
      w_cnt_d = '0;
    end else if (en) begin
      w_cnt_d = w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hp  <= CNT_W'(HALF_PERIOD);
    end else begin
      r_cnt <= w_cnt_d;
      r_hp  <= w_hp_d;
    end
  end

endmodule

// File: rtl/clk_half_period_gen.sv
// Programmable square-wave generator: clk_out stays high and low for hp_reg clk cycles each.
// Ports:
//   clk        : system clock, all state on its rising edge
//   rst_n      : asynchronous active-low reset
//   en         : run enable; low freezes all generator state (loads still honoured)
//   hp_load    : single-cycle strobe loading hp_value as the half period
//   hp_value   : new half period, 0 treated as 1
//   clk_out    : generated square wave (registered)
//   rise_pulse : one-cycle strobe coincident with clk_out 0->1
//   fall_pulse : one-cycle strobe coincident with clk_out 1->0
//   edge_count : clk_out toggles since reset, wraps modulo 2**EC_W
module clk_half_period_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EC_W        = EC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hp_load,
  input  logic [CNT_W-1:0] hp_value,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [EC_W-1:0]  edge_count
);

  if (!hp_in_range(longint'(HALF_PERIOD), CNT_W)) begin : g_bad_half_period
    $error("clk_half_period_gen: HALF_PERIOD must satisfy 1 <= HALF_PERIOD < 2**CNT_W");
  end

  logic            w_terminal;
  logic            r_clk_out;
  logic            r_rise;
  logic            r_fall;
  logic [EC_W-1:0] r_edge_count;

  clk_half_period_counter #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .hp_load  (hp_load),
    .hp_value (hp_value),
    .terminal (w_terminal)
  );

  // Strobes are computed from the pre-toggle level so they line up with the new clk_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_rise <= w_terminal && !r_clk_out;
      r_fall <= w_terminal && r_clk_out;
      if (w_terminal) begin
        r_clk_out    <= !r_clk_out;
        r_edge_count <= r_edge_count + EC_W'(1);
      end
    end
  end

  assign clk_out    = r_clk_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign edge_count = r_edge_count;

endmodule

// File: tb/tb_clk_half_period_gen.sv
// Bench for clk_half_period_gen: three instances (HALF_PERIOD 1 and 3, and a 4-bit edge
// counter) share one stimulus stream and are each compared against a reference model.
module tb_clk_half_period_gen;

  localparam int unsigned NDUT = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        hp_load;
  logic [15:0] hp_value;

  logic        o_clk  [NDUT];
  logic        o_rise [NDUT];
  logic        o_fall [NDUT];
  logic [31:0] o_ec   [NDUT];
  logic [3:0]  ec_small;

  int checks;
  int errors;

  // Reference model state, one entry per instance.
  int unsigned     m_hp   [NDUT];
  int unsigned     m_pos  [NDUT]; // enabled cycles elapsed in the current phase
  bit              m_out  [NDUT];
  bit              m_rise [NDUT];
  bit              m_fall [NDUT];
  longint unsigned m_togg [NDUT]; // total toggles since reset, unwrapped
  int unsigned     hp_init [NDUT];
  longint unsigned ec_mod  [NDUT];

  clk_half_period_gen #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .hp_load(hp_load), .hp_value(hp_value),
    .clk_out(o_clk[0]), .rise_pulse(o_rise[0]), .fall_pulse(o_fall[0]), .edge_count(o_ec[0])
  );

  clk_half_period_gen #(.HALF_PERIOD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .hp_load(hp_load), .hp_value(hp_value),
    .clk_out(o_clk[1]), .rise_pulse(o_rise[1]), .fall_pulse(o_fall[1]), .edge_count(o_ec[1])
  );

  clk_half_period_gen #(.HALF_PERIOD(1), .EC_W(4)) dutw (
    .clk(clk), .rst_n(rst_n), .en(en), .hp_load(hp_load), .hp_value(hp_value),
    .clk_out(o_clk[2]), .rise_pulse(o_rise[2]), .fall_pulse(o_fall[2]), .edge_count(ec_small)
  );

  assign o_ec[2] = {28'd0, ec_small};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_hp[i]   = hp_init[i];
      m_pos[i]  = 0;
      m_out[i]  = 0;
      m_rise[i] = 0;
      m_fall[i] = 0;
      m_togg[i] = 0;
    end
  endtask

  // One rising edge: a phase lasts m_hp enabled cycles; a load restarts the phase.
  task automatic model_edge();
    for (int i = 0; i < NDUT; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (hp_load) begin
        m_hp[i]  = (hp_value == 0) ? 1 : int'(hp_value);
        m_pos[i] = 0;
      end else if (en) begin
        m_pos[i]++;
        if (m_pos[i] >= m_hp[i]) begin
          m_pos[i] = 0;
          m_out[i] = !m_out[i];
          m_togg[i]++;
          if (m_out[i]) m_rise[i] = 1; else m_fall[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("m%0d_clk_out", i), o_clk[i], m_out[i]);
      check($sformatf("m%0d_rise", i), o_rise[i], m_rise[i]);
      check($sformatf("m%0d_fall", i), o_fall[i], m_fall[i]);
      check($sformatf("m%0d_edge_count", i), o_ec[i], m_togg[i] % ec_mod[i]);
    end
  endtask

  // Advance one clock with the currently driven inputs, then compare.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit e, input bit ld, input int unsigned hv);
    en       = e;
    hp_load  = ld;
    hp_value = 16'(hv);
  endtask

  // Reset pulse placed between clock edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          en;
    bit          ld;
    int unsigned hv;
    bit          exp_clk;
    bit          exp_rise;
    bit          exp_fall;
    int unsigned exp_ec;
  } vec_t;

  vec_t vecs[10];

  initial begin
    checks = 0;
    errors = 0;
    hp_init = '{1, 3, 1};
    ec_mod  = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd16};
    rst_n = 1'b0;
    drive(0, 0, 0);
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Table for the HALF_PERIOD=1 instance: divide-by-2, freeze, and a zero load.
    vecs[0] = '{1, 0, 0, 1, 1, 0, 1};
    vecs[1] = '{1, 0, 0, 0, 0, 1, 2};
    vecs[2] = '{1, 0, 0, 1, 1, 0, 3};
    vecs[3] = '{1, 0, 0, 0, 0, 1, 4};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 4};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 4};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 4};
    vecs[7] = '{1, 0, 0, 1, 1, 0, 5};
    vecs[8] = '{1, 0, 0, 0, 0, 1, 6};
    vecs[9] = '{1, 1, 2, 0, 0, 0, 6};
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].en, vecs[v].ld, vecs[v].hv);
      cyc();
      check($sformatf("tbl%0d_clk_out", v), o_clk[0], vecs[v].exp_clk);
      check($sformatf("tbl%0d_rise", v), o_rise[0], vecs[v].exp_rise);
      check($sformatf("tbl%0d_fall", v), o_fall[0], vecs[v].exp_fall);
      check($sformatf("tbl%0d_edge_count", v), o_ec[0], vecs[v].exp_ec);
    end

    // 17 enabled cycles from reset: 4-bit counter wraps to 1, HP=3 has toggled 5 times.
    pulse_reset();
    drive(1, 0, 0);
    for (int c = 0; c < 17; c++) cyc();
    check("wrap_ec4", o_ec[2], 1);
    check("hp1_ec_after17", o_ec[0], 17);
    check("hp3_ec_after17", o_ec[1], 5);
    check("hp3_clk_after17", o_clk[1], 1);

    // HP=3: freeze for 4 cycles at cnt=1, then toggle on the 2nd resumed cycle.
    pulse_reset();
    drive(1, 0, 0);
    for (int c = 0; c < 4; c++) cyc();
    check("frz_clk_before", o_clk[1], 1);
    drive(0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("frz_clk_hold", o_clk[1], 1);
      check("frz_ec_hold", o_ec[1], 1);
      check("frz_no_strobe", {o_rise[1], o_fall[1]}, 0);
    end
    drive(1, 0, 0);
    cyc();
    check("resume1_clk", o_clk[1], 1);
    cyc();
    check("resume2_clk", o_clk[1], 0);
    check("resume2_fall", o_fall[1], 1);
    check("resume2_ec", o_ec[1], 2);

    // HP=3: load 5 in the cycle a toggle is due; toggle suppressed, then 5/5 phases.
    pulse_reset();
    drive(1, 0, 0);
    cyc();
    cyc();
    drive(1, 1, 5);
    cyc();
    check("load_no_toggle_clk", o_clk[1], 0);
    check("load_no_toggle_ec", o_ec[1], 0);
    drive(1, 0, 0);
    for (int c = 0; c < 4; c++) cyc();
    check("load_4_clk", o_clk[1], 0);
    cyc();
    check("load_5_rise", o_rise[1], 1);
    check("load_5_clk", o_clk[1], 1);
    for (int c = 0; c < 5; c++) cyc();
    check("load_10_fall", o_fall[1], 1);
    check("load_10_ec", o_ec[1], 2);

    // Async reset with clk_out=1 and edge_count=7 on the HP=1 instance.
    pulse_reset();
    drive(1, 0, 0);
    for (int c = 0; c < 7; c++) cyc();
    check("pre_rst_clk", o_clk[0], 1);
    check("pre_rst_ec", o_ec[0], 7);
    pulse_reset();
    check("post_rst_clk", o_clk[0], 0);
    check("post_rst_ec", o_ec[0], 0);
    // HP=3 instance must be back on its reset half period even after the earlier load.
    for (int c = 0; c < 3; c++) cyc();
    check("rst_hp_restored", o_ec[1], 1);

    // Randomized stimulus against the model.
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end
      cyc();
      for (int i = 0; i < NDUT; i++) begin
        check("rand_strobe_excl", o_rise[i] & o_fall[i], 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
